mc_control: RTL and testbench

Multi-cycle control FSM for the TSC datapath. Decodes `opcode`/`func_code` from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback states. Drives every datapath strobe, including `alu_mode`, which feeds the ALU-control decoder directly downstream. Also owns the halt flag and the retired-instruction counter.

---
 rtl/mc_control_pkg.sv | 81 ++++++++
 rtl/mc_control_if.sv | 47 ++++
 rtl/mc_control_inst_class_decode.sv | 41 ++++
 rtl/mc_control.sv | 199 +++++++++++++++++++
 tb/tb_mc_control.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_pkg
//  Purpose  : Shared types and encodings for the TSC multi-cycle controller.
//  Revision : 1.0
// ============================================================================
package mc_control_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // TSC opcodes (IR[15:12])
    localparam logic [3:0] c_op_bne = 4'd0;
    localparam logic [3:0] c_op_beq = 4'd1;
    localparam logic [3:0] c_op_bgz = 4'd2;
    localparam logic [3:0] c_op_blz = 4'd3;
    localparam logic [3:0] c_op_adi = 4'd4;
    localparam logic [3:0] c_op_ori = 4'd5;
    localparam logic [3:0] c_op_lhi = 4'd6;
    localparam logic [3:0] c_op_lwd = 4'd7;
    localparam logic [3:0] c_op_swd = 4'd8;
    localparam logic [3:0] c_op_jmp = 4'd9;
    localparam logic [3:0] c_op_jal = 4'd10;
    localparam logic [3:0] c_op_alu = 4'd15;

    // Function codes under c_op_alu (IR[5:0])
    localparam logic [5:0] c_fn_add = 6'd0;
    localparam logic [5:0] c_fn_sub = 6'd1;
    localparam logic [5:0] c_fn_and = 6'd2;
    localparam logic [5:0] c_fn_orr = 6'd3;
    localparam logic [5:0] c_fn_not = 6'd4;
    localparam logic [5:0] c_fn_tcp = 6'd5;
    localparam logic [5:0] c_fn_shl = 6'd6;
    localparam logic [5:0] c_fn_shr = 6'd7;
    localparam logic [5:0] c_fn_jpr = 6'd25;
    localparam logic [5:0] c_fn_jrl = 6'd26;
    localparam logic [5:0] c_fn_wwd = 6'd28;
    localparam logic [5:0] c_fn_hlt = 6'd29;

    // Datapath mux selectors
    localparam logic [1:0] c_srcb_b       = 2'd0;
    localparam logic [1:0] c_srcb_one     = 2'd1;
    localparam logic [1:0] c_srcb_imm     = 2'd2;

    localparam logic [1:0] c_pcsrc_alu    = 2'd0;
    localparam logic [1:0] c_pcsrc_aluout = 2'd1;
    localparam logic [1:0] c_pcsrc_jump   = 2'd2;
    localparam logic [1:0] c_pcsrc_rega   = 2'd3;

    localparam logic [1:0] c_regdst_rt    = 2'd0;
    localparam logic [1:0] c_regdst_rd    = 2'd1;
    localparam logic [1:0] c_regdst_link  = 2'd2;

    localparam logic [1:0] c_m2r_aluout   = 2'd0;
    localparam logic [1:0] c_m2r_mdr      = 2'd1;
    localparam logic [1:0] c_m2r_pc       = 2'd2;
    localparam logic [1:0] c_m2r_lhi      = 2'd3;

    // One-hot instruction class
    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic lhi;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jump_reg;
        logic wwd;
        logic hlt;
        logic invalid;
    } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_if
//  Purpose  : Instruction/handshake inputs and datapath strobes of mc_control.
//  Revision : 1.0
// ============================================================================
interface mc_control_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic [5:0]       func_code;
    logic             bcond;
    logic             mem_ready;

    logic             alu_mode;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       pc_source;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             output_active;
    logic             is_halted;
    logic [CNT_W-1:0] num_inst;

    // master: the controller; slave: the datapath it steers
    modport master (
        input  opcode, func_code, bcond, mem_ready,
        output alu_mode, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
               ir_write, pc_write, reg_write, pc_source, reg_dst, mem_to_reg,
               output_active, is_halted, num_inst
    );

    modport slave (
        output opcode, func_code, bcond, mem_ready,
        input  alu_mode, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
               ir_write, pc_write, reg_write, pc_source, reg_dst, mem_to_reg,
               output_active, is_halted, num_inst
    );

endinterface
`default_nettype wire

// File: rtl/mc_control_inst_class_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_inst_class_decode
//  Purpose  : Combinational opcode/func_code to one-hot instruction class.
//  Revision : 1.0
// ============================================================================
module mc_control_inst_class_decode
    import mc_control_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [5:0]  func_code,
    output inst_class_t inst_class
);

    always_comb begin
        inst_class = '0;
        case (opcode)
            c_op_bne, c_op_beq,
            c_op_bgz, c_op_blz: inst_class.branch = 1'b1;
            c_op_adi, c_op_ori: inst_class.alu_i  = 1'b1;
            c_op_lhi:           inst_class.lhi    = 1'b1;
            c_op_lwd:           inst_class.load   = 1'b1;
            c_op_swd:           inst_class.store  = 1'b1;
            c_op_jmp, c_op_jal: inst_class.jump   = 1'b1;
            c_op_alu: begin
                case (func_code)
                    c_fn_add, c_fn_sub, c_fn_and, c_fn_orr,
                    c_fn_not, c_fn_tcp, c_fn_shl, c_fn_shr:
                                        inst_class.alu_r    = 1'b1;
                    c_fn_jpr, c_fn_jrl: inst_class.jump_reg = 1'b1;
                    c_fn_wwd:           inst_class.wwd      = 1'b1;
                    c_fn_hlt:           inst_class.hlt      = 1'b1;
                    default:            inst_class.invalid  = 1'b1;
                endcase
            end
            default:            inst_class.invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle control FSM for the TSC datapath, with halt flag
//             and retired-instruction counter.
//  Revision : 1.0
// ============================================================================
module mc_control
    import mc_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_num_inst;
    logic             w_retire;
    logic             w_link;
    inst_class_t      w_cls;

    logic             w_alu_mode;
    logic             w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic             w_i_or_d;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_pc_write;
    logic             w_reg_write;
    logic [1:0]       w_pc_source;
    logic [1:0]       w_reg_dst;
    logic [1:0]       w_mem_to_reg;
    logic             w_output_active;

    mc_control_inst_class_decode u_inst_class_decode (
        .opcode     (bus.opcode),
        .func_code  (bus.func_code),
        .inst_class (w_cls)
    );

    // JAL and JRL additionally write the return address into R2
    assign w_link = (bus.opcode == c_op_jal) ||
                    ((bus.opcode == c_op_alu) && (bus.func_code == c_fn_jrl));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_retire        = 1'b0;
        w_alu_mode      = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = c_srcb_b;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_pc_source     = c_pcsrc_alu;
        w_reg_dst       = c_regdst_rt;
        w_mem_to_reg    = c_m2r_aluout;
        w_output_active = 1'b0;

        if (reset) begin
            w_state_next = ST_IF;
        end else begin
            case (r_state)
                ST_IF: begin
                    w_mem_read  = 1'b1;
                    w_alu_src_b = c_srcb_one;
                    if (bus.mem_ready) begin
                        w_ir_write   = 1'b1;
                        w_pc_write   = 1'b1;
                        w_state_next = ST_ID;
                    end
                end

                ST_ID: begin
                    // ALU precomputes the branch target into ALUOut
                    w_alu_src_b = c_srcb_imm;
                    if (w_cls.jump || w_cls.jump_reg) begin
                        w_pc_write  = 1'b1;
                        w_pc_source = w_cls.jump ? c_pcsrc_jump : c_pcsrc_rega;
                        if (w_link) begin
                            w_reg_write  = 1'b1;
                            w_reg_dst    = c_regdst_link;
                            w_mem_to_reg = c_m2r_pc;
                        end
                        w_retire     = 1'b1;
                        w_state_next = ST_IF;
                    end else if (w_cls.wwd) begin
                        w_output_active = 1'b1;
                        w_retire        = 1'b1;
                        w_state_next    = ST_IF;
                    end else if (w_cls.hlt) begin
                        w_state_next = ST_HALT;
                    end else if (w_cls.invalid) begin
                        w_retire     = 1'b1;
                        w_state_next = ST_IF;
                    end else begin
                        w_state_next = ST_EX;
                    end
                end

                ST_EX: begin
                    if (w_cls.alu_r || w_cls.alu_i) begin
                        w_alu_mode   = 1'b1;
                        w_alu_src_a  = 1'b1;
                        w_alu_src_b  = w_cls.alu_r ? c_srcb_b : c_srcb_imm;
                        w_state_next = ST_WB;
                    end else if (w_cls.lhi) begin
                        w_state_next = ST_WB;
                    end else if (w_cls.load || w_cls.store) begin
                        w_alu_src_a  = 1'b1;
                        w_alu_src_b  = c_srcb_imm;
                        w_state_next = ST_MEM;
                    end else if (w_cls.branch) begin
                        w_alu_mode   = 1'b1;
                        w_alu_src_a  = 1'b1;
                        w_alu_src_b  = c_srcb_b;
                        w_pc_write   = bus.bcond;
                        w_pc_source  = c_pcsrc_aluout;
                        w_retire     = 1'b1;
                        w_state_next = ST_IF;
                    end else begin
                        w_state_next = ST_IF;
                    end
                end

                ST_MEM: begin
                    w_i_or_d    = 1'b1;
                    w_mem_read  = w_cls.load;
                    w_mem_write = w_cls.store;
                    if (bus.mem_ready) begin
                        if (w_cls.load) begin
                            w_state_next = ST_WB;
                        end else begin
                            w_retire     = 1'b1;
                            w_state_next = ST_IF;
                        end
                    end
                end

                ST_WB: begin
                    w_reg_write  = 1'b1;
                    w_reg_dst    = w_cls.alu_r ? c_regdst_rd : c_regdst_rt;
                    w_mem_to_reg = w_cls.load ? c_m2r_mdr :
                                   (w_cls.lhi ? c_m2r_lhi : c_m2r_aluout);
                    w_retire     = 1'b1;
                    w_state_next = ST_IF;
                end

                ST_HALT: begin
                    w_state_next = ST_HALT;
                end

                default: begin
                    w_state_next = ST_IF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_inst <= '0;
        end else if (w_retire) begin
            r_num_inst <= r_num_inst + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.alu_mode      = w_alu_mode;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.ir_write      = w_ir_write;
    assign bus.pc_write      = w_pc_write;
    assign bus.reg_write     = w_reg_write;
    assign bus.pc_source     = w_pc_source;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.output_active = w_output_active;
    assign bus.is_halted     = (r_state == ST_HALT);
    assign bus.num_inst      = r_num_inst;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Randomized scoreboard bench for mc_control against a per-
//             instruction cycle model.
//  Revision : 1.0
// ============================================================================
module tb_mc_control;

    // Narrow counter so the wrap from all-ones to zero occurs in a short run
    localparam int CW = 8;

    localparam int K_ALUR = 0, K_ADI = 1, K_ORI = 2, K_LHI = 3, K_LWD = 4,
                   K_SWD  = 5, K_BR  = 6, K_JMP = 7, K_JAL = 8, K_JPR = 9,
                   K_JRL  = 10, K_WWD = 11, K_HLT = 12, K_NOP = 13;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mc_control_if #(.CNT_W(CW)) bus ();

    mc_control #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       alu_mode;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] pc_source;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       output_active;
        logic       is_halted;
    } obs_t;

    typedef struct {
        obs_t          e;
        logic [CW-1:0] cnt;
        bit            chk_halt;
        string         tag;
    } item_t;

    item_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc_no = 0;
    logic [CW-1:0] m_cnt  = '0;

    function automatic obs_t observe();
        obs_t o;
        o.alu_mode      = bus.alu_mode;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.i_or_d        = bus.i_or_d;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.ir_write      = bus.ir_write;
        o.pc_write      = bus.pc_write;
        o.reg_write     = bus.reg_write;
        o.pc_source     = bus.pc_source;
        o.reg_dst       = bus.reg_dst;
        o.mem_to_reg    = bus.mem_to_reg;
        o.output_active = bus.output_active;
        o.is_halted     = bus.is_halted;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int classify(input logic [3:0] op, input logic [5:0] fn);
        if (op <= 4'd3) return K_BR;
        case (op)
            4'd4:  return K_ADI;
            4'd5:  return K_ORI;
            4'd6:  return K_LHI;
            4'd7:  return K_LWD;
            4'd8:  return K_SWD;
            4'd9:  return K_JMP;
            4'd10: return K_JAL;
            4'd15: begin
                if (fn <= 6'd7) return K_ALUR;
                if (fn == 6'd25) return K_JPR;
                if (fn == 6'd26) return K_JRL;
                if (fn == 6'd28) return K_WWD;
                if (fn == 6'd29) return K_HLT;
                return K_NOP;
            end
            default: return K_NOP;
        endcase
    endfunction

    // Monitor: the controller presents a strobe set every cycle
    always @(negedge clk) begin
        item_t it;
        obs_t  a;
        obs_t  x;
        cyc_no++;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            a  = observe();
            x  = it.e;
            if (!it.chk_halt) begin
                a.is_halted = 1'b0;
                x.is_halted = 1'b0;
            end
            checks++;
            if ((a !== x) || (bus.num_inst !== it.cnt)) begin
                errors++;
                $display("FAIL %s @cycle %0d: got strobes=%h num_inst=%0d, expected strobes=%h num_inst=%0d",
                         it.tag, cyc_no, a, bus.num_inst, x, it.cnt);
            end
        end
    end

    // One clock cycle of stimulus with its expected strobes and count
    task automatic cyc(input obs_t e, input logic mr, input logic bc, input logic rst_v,
                       input bit retire, input bit chk_halt, input string tag);
        item_t it;
        bus.mem_ready = mr;
        bus.bcond     = bc;
        reset         = rst_v;
        it.e = e; it.cnt = m_cnt; it.chk_halt = chk_halt; it.tag = tag;
        sb.push_back(it);
        @(posedge clk);
        #1;
        if (rst_v)       m_cnt = '0;
        else if (retire) m_cnt = m_cnt + 1'b1;
    endtask

    // bcv < 0: random branch outcome. abort_mem: reset during the last MEM wait.
    task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input int bcv, input bit abort_mem);
        obs_t e;
        int   k;
        logic bc;
        k = classify(op, fn);
        bus.opcode    = op;
        bus.func_code = fn;

        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
        repeat (fw) cyc(e, 1'b0, rb(), 1'b0, 0, 1, "IF-wait");
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc(e, 1'b1, rb(), 1'b0, 0, 1, "IF");

        e = '0; e.alu_src_b = 2'd2;
        case (k)
            K_JMP, K_JAL, K_JPR, K_JRL: begin
                e.pc_write  = 1'b1;
                e.pc_source = (k == K_JMP || k == K_JAL) ? 2'd2 : 2'd3;
                if (k == K_JAL || k == K_JRL) begin
                    e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
                end
                cyc(e, rb(), rb(), 1'b0, 1, 1, "ID-jump");
                return;
            end
            K_WWD: begin
                e.output_active = 1'b1;
                cyc(e, rb(), rb(), 1'b0, 1, 1, "ID-wwd");
                return;
            end
            K_NOP: begin
                cyc(e, rb(), rb(), 1'b0, 1, 1, "ID-nop");
                return;
            end
            K_HLT: begin
                cyc(e, rb(), rb(), 1'b0, 0, 1, "ID-hlt");
                return;
            end
            default: cyc(e, rb(), rb(), 1'b0, 0, 1, "ID");
        endcase

        e = '0;
        case (k)
            K_BR: begin
                bc = (bcv < 0) ? rb() : bcv[0];
                e.alu_mode = 1'b1; e.alu_src_a = 1'b1;
                e.pc_write = bc;   e.pc_source = 2'd1;
                cyc(e, rb(), bc, 1'b0, 1, 1, "EX-branch");
                return;
            end
            K_ALUR, K_ADI, K_ORI: begin
                e.alu_mode = 1'b1; e.alu_src_a = 1'b1;
                e.alu_src_b = (k == K_ALUR) ? 2'd0 : 2'd2;
                cyc(e, rb(), rb(), 1'b0, 0, 1, "EX-alu");
            end
            K_LHI: cyc(e, rb(), rb(), 1'b0, 0, 1, "EX-lhi");
            default: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                cyc(e, rb(), rb(), 1'b0, 0, 1, "EX-mem");
            end
        endcase

        if (k == K_LWD || k == K_SWD) begin
            e = '0; e.i_or_d = 1'b1;
            e.mem_read  = (k == K_LWD);
            e.mem_write = (k == K_SWD);
            repeat (mw) cyc(e, 1'b0, rb(), 1'b0, 0, 1, "MEM-wait");
            if (abort_mem) begin
                cyc('0, 1'b0, rb(), 1'b1, 0, 1, "reset-in-MEM");
                return;
            end
            cyc(e, 1'b1, rb(), 1'b0, (k == K_SWD), 1, "MEM");
            if (k == K_SWD) return;
        end

        e = '0; e.reg_write = 1'b1;
        e.reg_dst    = (k == K_ALUR) ? 2'd1 : 2'd0;
        e.mem_to_reg = (k == K_LWD) ? 2'd1 : ((k == K_LHI) ? 2'd3 : 2'd0);
        cyc(e, rb(), rb(), 1'b0, 1, 1, "WB");
    endtask

    initial begin
        logic [3:0] op;
        logic [5:0] fn;
        obs_t       h;
        bus.opcode = '0; bus.func_code = '0; bus.bcond = 1'b0; bus.mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_cnt = '0;
        cyc('0, 1'b1, 1'b1, 1'b1, 0, 1, "reset");

        run_inst(4'd4, 6'd0, 0, 0, -1, 0);
        run_inst(4'd7, 6'd0, 0, 3, -1, 0);
        run_inst(4'd1, 6'd0, 0, 0, 1, 0);
        run_inst(4'd1, 6'd0, 1, 0, 0, 0);
        run_inst(4'd15, 6'd26, 0, 0, -1, 0);

        for (int i = 0; i < 320; i++) begin
            op = 4'($urandom_range(0, 15));
            fn = 6'($urandom_range(0, 63));
            if (op == 4'd15) begin
                case ($urandom_range(0, 3))
                    0, 1:    fn = 6'($urandom_range(0, 7));
                    2:       fn = ($urandom_range(0, 2) == 0) ? 6'd25 :
                                  (($urandom_range(0, 1) == 0) ? 6'd26 : 6'd28);
                    default: ;
                endcase
                if (fn == 6'd29) fn = 6'd30;
            end
            run_inst(op, fn, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                     $urandom_range(0, 3), -1, 0);
        end

        // Abandon a store in a memory wait
        run_inst(4'd8, 6'd0, 0, 2, -1, 1);
        run_inst(4'd6, 6'd0, 0, 0, -1, 0);

        // Halt is absorbing and leaves the counter alone
        run_inst(4'd15, 6'd29, 0, 0, -1, 0);
        h = '0; h.is_halted = 1'b1;
        repeat (20) begin
            bus.opcode    = 4'($urandom);
            bus.func_code = 6'($urandom);
            cyc(h, rb(), rb(), 1'b0, 0, 1, "HALT");
        end
        cyc('0, rb(), rb(), 1'b1, 0, 0, "reset-from-HALT");
        run_inst(4'd9, 6'd0, 0, 0, -1, 0);
        run_inst(4'd8, 6'd0, 0, 1, -1, 0);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard-drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
